id_ex_stage: RTL

- Pipeline boundary register between decode (register-file read) and execute.
- Captures the decoded instruction together with both register-file read operands.
- Writes landing in the same cycle are bypassed into the captured operands, because the register file updates only on the clock edge.
- Detects load-use hazards, inserts bubbles on stall or branch flush, and counts inserted bubbles for performance monitoring.

---
 rtl/id_ex_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX boundary: captures decode + bypassed operands,
// detects load-use hazards, inserts bubbles, counts them.
// Ports: clk, rst (async, active-low), id_* decode slot,
//   wb_* writeback, ex_flush; ex_* execute slot, stall,
//   stall_cnt, flush_cnt.
module id_ex_stage #(
  parameter int DATA    = 32,
  parameter int ADDRESS = 5,
  parameter int CTRL_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [DATA-1:0]    id_pc,
  input  logic [ADDRESS-1:0] id_rs1,
  input  logic [ADDRESS-1:0] id_rs2,
  input  logic [ADDRESS-1:0] id_rd,
  input  logic [DATA-1:0]    id_rd1,
  input  logic [DATA-1:0]    id_rd2,
  input  logic [DATA-1:0]    id_imm,
  input  logic [CTRL_W-1:0]  id_ctrl,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               wb_we,
  input  logic [ADDRESS-1:0] wb_rd,
  input  logic [DATA-1:0]    wb_wd,
  input  logic               ex_flush,
  output logic               ex_valid,
  output logic [DATA-1:0]    ex_pc,
  output logic [ADDRESS-1:0] ex_rs1,
  output logic [ADDRESS-1:0] ex_rs2,
  output logic [ADDRESS-1:0] ex_rd,
  output logic [DATA-1:0]    ex_op1,
  output logic [DATA-1:0]    ex_op2,
  output logic [DATA-1:0]    ex_imm,
  output logic [CTRL_W-1:0]  ex_ctrl,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               stall,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic               valid_q;
  logic [DATA-1:0]    pc_q;
  logic [ADDRESS-1:0] rs1_q;
  logic [ADDRESS-1:0] rs2_q;
  logic [ADDRESS-1:0] rd_q;
  logic [DATA-1:0]    op1_q;
  logic [DATA-1:0]    op2_q;
  logic [DATA-1:0]    imm_q;
  logic [CTRL_W-1:0]  ctrl_q;
  logic               rw_q;
  logic               mr_q;
  logic [CNT_W-1:0]   scnt_q;
  logic [CNT_W-1:0]   fcnt_q;

  logic [DATA-1:0]    op1_d;
  logic [DATA-1:0]    op2_d;
  logic               hz;

  // Conservative: both rs fields checked regardless of use.
  assign hz = valid_q & mr_q & (rd_q != '0) & id_valid
            & ((id_rs1 == rd_q) | (id_rs2 == rd_q));
  assign stall = hz & ~ex_flush;

  // x0 forced to zero; a same-cycle write wins over
  // the stale register-file read.
  always_comb begin
    op1_d = id_rd1;
    if (id_rs1 == '0)
      op1_d = '0;
    else if (wb_we && (wb_rd == id_rs1))
      op1_d = wb_wd;
  end

  always_comb begin
    op2_d = id_rd2;
    if (id_rs2 == '0)
      op2_d = '0;
    else if (wb_we && (wb_rd == id_rs2))
      op2_d = wb_wd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      scnt_q  <= '0;
      fcnt_q  <= '0;
    end else if (ex_flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      if (id_valid && (fcnt_q != '1))
        fcnt_q <= fcnt_q + CNT_W'(1);
    end else if (stall) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      if (scnt_q != '1)
        scnt_q <= scnt_q + CNT_W'(1);
    end else begin
      valid_q <= id_valid;
      pc_q    <= id_pc;
      rs1_q   <= id_rs1;
      rs2_q   <= id_rs2;
      rd_q    <= id_rd;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      imm_q   <= id_imm;
      ctrl_q  <= id_ctrl;
      rw_q    <= id_reg_write & id_valid;
      mr_q    <= id_mem_read & id_valid;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_rd        = rd_q;
  assign ex_op1       = op1_q;
  assign ex_op2       = op2_q;
  assign ex_imm       = imm_q;
  assign ex_ctrl      = ctrl_q;
  assign ex_reg_write = rw_q;
  assign ex_mem_read  = mr_q;
  assign stall_cnt    = scnt_q;
  assign flush_cnt    = fcnt_q;

endmodule
